// File: rtl/mask_prng_pkg.sv
// Shared definitions for the mask PRNG and its consumers.
//
// Holds the LFSR geometry (64-bit Fibonacci, taps 63/62/60/59), the seed word
// layout, the FSM state type and the num_needed() helper that maps a share
// count onto the number of fresh random words per enabled cycle. share_zero
// imports the same helper, so both blocks agree on the mask width.

package mask_prng_pkg;

  localparam int unsigned LFSR_WIDTH      = 64;
  localparam int unsigned SEED_WORD_WIDTH = 32;
  localparam int unsigned SEED_WORDS      = 2;

  // Feedback taps of the maximal-length polynomial.
  localparam int unsigned TAP_0 = 63;
  localparam int unsigned TAP_1 = 62;
  localparam int unsigned TAP_2 = 60;
  localparam int unsigned TAP_3 = 59;

  typedef enum logic [1:0] {
    SEED = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Random words needed per cycle by a consumer with num_shares shares.
  // Returns 0 for unsupported share counts so instantiators can reject them.
  function automatic int unsigned num_needed(input int unsigned num_shares);
    int unsigned n;
    case (num_shares)
      32'd2:        n = 32'd1;
      32'd3:        n = 32'd2;
      32'd4, 32'd5: n = num_shares;
      default:      n = 32'd0;
    endcase
    return n;
  endfunction

  function automatic logic lfsr_feedback(input logic [LFSR_WIDTH-1:0] s);
    return s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3];
  endfunction

  // One shift: the new bit enters at bit 0, the oldest bit leaves at the top.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], lfsr_feedback(s)};
  endfunction

endpackage

// File: rtl/mask_prng_lfsr_unroll.sv
// Combinational unrolled LFSR.
//
// Maps a 64-bit Fibonacci LFSR state onto the state reached after STEPS
// single-bit steps. After the unroll the STEPS newest bits sit in
// state_o[STEPS-1:0], bit 0 being the most recent. STEPS = 0 is a wire.
//
// Ports:
//   state_i  current LFSR state
//   state_o  state after STEPS steps

module lfsr_unroll
  import mask_prng_pkg::*;
#(
  parameter int unsigned STEPS = 1
) (
  input  logic [LFSR_WIDTH-1:0] state_i,
  output logic [LFSR_WIDTH-1:0] state_o
);

  always_comb begin
    logic [LFSR_WIDTH-1:0] s;
    s = state_i;
    for (int unsigned i = 0; i < STEPS; i++) begin
      s = lfsr_step(s);
    end
    state_o = s;
  end

endmodule

// File: rtl/mask_prng.sv
// Mask PRNG feeding the zero-sharing stage.
//
// A 64-bit LFSR is seeded with two 32-bit words over a valid/ready handshake
// (word 0 -> bits [31:0], word 1 -> bits [63:32]); an all-zero seed is
// replaced by 64'h1 so the LFSR never locks up. After seeding the LFSR free-runs
// for WARMUP_CYCLES advances, then streams OUT_BITS fresh bits per enabled cycle
// with one cycle of latency. in_reseed restarts seeding from any state and
// beats both enable and a same-cycle seed handshake.
//
// out_valid rises on entry to RUN, before any enabled advance; out_random is
// still zero at that point and must not be used until the consumer has
// enabled once.
//
// Ports:
//   in_clock        clock
//   in_reset        asynchronous active-low reset
//   in_seed         seed word
//   in_seed_valid   seed word valid
//   out_seed_ready  seed word accepted when valid && ready (SEED state only)
//   in_reseed       single-cycle request to restart seeding
//   in_enable       consumer requests a fresh mask this cycle
//   out_random      NUM_NEEDED words of BIT_WIDTH bits, word i at [i*BIT_WIDTH +: BIT_WIDTH]
//   out_valid       out_random holds fresh data (RUN state)

module mask_prng
  import mask_prng_pkg::*;
#(
  parameter int unsigned NUM_SHARES    = 2,
  parameter int unsigned BIT_WIDTH     = 2,
  parameter int unsigned WARMUP_CYCLES = 16,
  // Derived; not meant to be overridden.
  parameter int unsigned NUM_NEEDED    = num_needed(NUM_SHARES),
  parameter int unsigned OUT_BITS      = NUM_NEEDED * BIT_WIDTH
) (
  input  logic                       in_clock,
  input  logic                       in_reset,
  input  logic [SEED_WORD_WIDTH-1:0] in_seed,
  input  logic                       in_seed_valid,
  output logic                       out_seed_ready,
  input  logic                       in_reseed,
  input  logic                       in_enable,
  output logic [OUT_BITS-1:0]        out_random,
  output logic                       out_valid
);

  // ---------------------------------------------------------------------------
  // Elaboration checks
  // ---------------------------------------------------------------------------
  if (NUM_NEEDED == 0) begin : g_bad_num_shares
    $error("mask_prng: NUM_SHARES must be 2, 3, 4 or 5");
  end

  if (OUT_BITS > LFSR_WIDTH) begin : g_bad_out_bits
    $error("mask_prng: NUM_NEEDED * BIT_WIDTH must not exceed the LFSR width");
  end

  if (OUT_BITS == 0) begin : g_zero_out_bits
    $error("mask_prng: output width must be non-zero");
  end

  // ---------------------------------------------------------------------------
  // Local parameters
  // ---------------------------------------------------------------------------
  // Warm-up counter holds 0..WARMUP_CYCLES; keep at least one bit for the
  // WARMUP_CYCLES = 0 build, where WARM is never entered.
  localparam int unsigned CNT_W  = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam int unsigned WIDX_W = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1;

  localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WARMUP_CYCLES);
  localparam logic [WIDX_W-1:0] WORD_LAST = WIDX_W'(SEED_WORDS - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e                  fsm_q,      fsm_d;
  logic [LFSR_WIDTH-1:0]   lfsr_q,     lfsr_d;
  logic [WIDX_W-1:0]       word_idx_q, word_idx_d;
  logic [CNT_W-1:0]        cnt_q,      cnt_d;
  logic [OUT_BITS-1:0]     random_q,   random_d;
  logic                    valid_q,    valid_d;
  logic                    ready_q,    ready_d;

  // ---------------------------------------------------------------------------
  // One advance = OUT_BITS unrolled steps
  // ---------------------------------------------------------------------------
  logic [LFSR_WIDTH-1:0] lfsr_adv;

  lfsr_unroll #(
    .STEPS (OUT_BITS)
  ) u_lfsr_unroll (
    .state_i (lfsr_q),
    .state_o (lfsr_adv)
  );

  // ready_q is only ever set while in SEED, so it alone qualifies the handshake.
  logic seed_fire;
  assign seed_fire = in_seed_valid && ready_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [LFSR_WIDTH-1:0] assembled;

    fsm_d      = fsm_q;
    lfsr_d     = lfsr_q;
    word_idx_d = word_idx_q;
    cnt_d      = cnt_q;
    random_d   = random_q;
    assembled  = lfsr_q;

    if (in_reseed) begin
      // LFSR contents are kept; they are overwritten word by word on reseed.
      fsm_d      = SEED;
      word_idx_d = '0;
      cnt_d      = '0;
      random_d   = '0;
    end else begin
      unique case (fsm_q)
        SEED: begin
          if (seed_fire) begin
            assembled[SEED_WORD_WIDTH * int'(word_idx_q) +: SEED_WORD_WIDTH] = in_seed;
            if (word_idx_q == WORD_LAST) begin
              // The all-zero state is the LFSR's fixed point; escape it.
              lfsr_d     = (assembled == '0) ? LFSR_WIDTH'(1) : assembled;
              word_idx_d = '0;
              cnt_d      = '0;
              fsm_d      = (WARMUP_CYCLES > 0) ? WARM : RUN;
            end else begin
              lfsr_d     = assembled;
              word_idx_d = word_idx_q + 1'b1;
            end
          end
        end

        WARM: begin
          lfsr_d = lfsr_adv;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_d == WARM_LAST) begin
            fsm_d = RUN;
          end
        end

        RUN: begin
          if (in_enable) begin
            lfsr_d   = lfsr_adv;
            random_d = lfsr_adv[OUT_BITS-1:0];
          end
        end

        default: begin
          fsm_d      = SEED;
          word_idx_d = '0;
          cnt_d      = '0;
          random_d   = '0;
        end
      endcase
    end

    // Handshake and valid flags follow the state being entered.
    valid_d = (fsm_d == RUN);
    ready_d = (fsm_d == SEED);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      fsm_q      <= SEED;
      lfsr_q     <= '0;
      word_idx_q <= '0;
      cnt_q      <= '0;
      random_q   <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      lfsr_q     <= lfsr_d;
      word_idx_q <= word_idx_d;
      cnt_q      <= cnt_d;
      random_q   <= random_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
    end
  end

  assign out_seed_ready = ready_q;
  assign out_valid      = valid_q;
  assign out_random     = random_q;

endmodule

// File: tb/tb_mask_prng.sv
// Bench for mask_prng: two instances (2 shares / 2 bits / no warm-up, and
// 3 shares / 4 bits / 16 warm-up cycles). Stimulus pushes expected masks into
// per-instance queues; monitors pop and compare the cycle after each accepted
// enable.

module tb_mask_prng;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance 0: NUM_SHARES=2, BIT_WIDTH=2, WARMUP_CYCLES=0
  logic [31:0] seed0;
  logic        sv0, rdy0, rs0, en0, vld0;
  logic [1:0]  rnd0;

  // Instance 1: NUM_SHARES=3, BIT_WIDTH=4, WARMUP_CYCLES=16
  logic [31:0] seed1;
  logic        sv1, rdy1, rs1, en1, vld1;
  logic [7:0]  rnd1;

  mask_prng #(
    .NUM_SHARES    (2),
    .BIT_WIDTH     (2),
    .WARMUP_CYCLES (0)
  ) dut0 (
    .in_clock       (clk),
    .in_reset       (rst_n),
    .in_seed        (seed0),
    .in_seed_valid  (sv0),
    .out_seed_ready (rdy0),
    .in_reseed      (rs0),
    .in_enable      (en0),
    .out_random     (rnd0),
    .out_valid      (vld0)
  );

  mask_prng #(
    .NUM_SHARES    (3),
    .BIT_WIDTH     (4),
    .WARMUP_CYCLES (16)
  ) dut1 (
    .in_clock       (clk),
    .in_reset       (rst_n),
    .in_seed        (seed1),
    .in_seed_valid  (sv1),
    .out_seed_ready (rdy1),
    .in_reseed      (rs1),
    .in_enable      (en1),
    .out_random     (rnd1),
    .out_valid      (vld1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [63:0] m0, m1;

  // Golden LFSR: x^64 feedback from bits 63, 62, 60, 59, new bit at bit 0.
  function automatic logic [63:0] model_adv(input logic [63:0] s, input int steps);
    logic [63:0] t;
    t = s;
    for (int i = 0; i < steps; i++) begin
      t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
    end
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  logic fire0 = 1'b0;
  logic fire1 = 1'b0;

  always @(posedge clk) begin
    fire0 <= rst_n && en0 && vld0 && !rs0;
    fire1 <= rst_n && en1 && vld1 && !rs1;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (fire0) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mon0_unexpected: got %0h, expected no output", rnd0);
      end else begin
        e = q0.pop_front();
        check("mon0_random", 64'(rnd0), 64'(e[1:0]));
        check("mon0_valid", 64'(vld0), 64'd1);
      end
    end
    if (fire1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mon1_unexpected: got %0h, expected no output", rnd1);
      end else begin
        e = q1.pop_front();
        check("mon1_random", 64'(rnd1), 64'(e));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send0(input logic [31:0] w);
    int g;
    @(negedge clk);
    seed0 = w;
    sv0   = 1'b1;
    g     = 0;
    while (!rdy0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL send0_timeout: got ready=%b, expected 1", rdy0);
    end
  endtask

  task automatic send1(input logic [31:0] w);
    int g;
    @(negedge clk);
    seed1 = w;
    sv1   = 1'b1;
    g     = 0;
    while (!rdy1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL send1_timeout: got ready=%b, expected 1", rdy1);
    end
  endtask

  task automatic en_push0(input logic [7:0] e);
    @(negedge clk);
    en0 = 1'b1;
    q0.push_back(e);
  endtask

  task automatic idle0();
    @(negedge clk);
    en0 = 1'b0;
  endtask

  task automatic seed_stream0(input logic [31:0] a, input logic [31:0] b, input int n);
    send0(a);
    send0(b);
    @(negedge clk);
    sv0 = 1'b0;
    check("t5_valid_after_seed", 64'(vld0), 64'd1);
    m0 = {b, a};
    for (int i = 0; i < n; i++) begin
      m0 = model_adv(m0, 2);
      en_push0(8'(m0[1:0]));
    end
    idle0();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b1;
    seed0 = '0; sv0 = 1'b0; rs0 = 1'b0; en0 = 1'b0;
    seed1 = '0; sv1 = 1'b0; rs1 = 1'b0; en1 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_valid", 64'(vld0), 64'd0);
    check("reset_ready", 64'(rdy0), 64'd0);
    check("reset_random", 64'(rnd0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_release_ready_low", 64'(rdy0), 64'd0);
    @(negedge clk);
    check("reset_release_ready_high", 64'(rdy0), 64'd1);

    // Seed 64'h8000_0000_0000_0000, one enable -> 2'b10.
    send0(32'h0000_0000);
    send0(32'h8000_0000);
    @(negedge clk);
    sv0 = 1'b0;
    check("t2_valid", 64'(vld0), 64'd1);
    check("t2_ready_low", 64'(rdy0), 64'd0);
    en_push0(8'h02);
    idle0();
    check("t2_random_direct", 64'(rnd0), 64'h2);

    // Asynchronous reset between clock edges.
    #1 rst_n = 1'b0;
    #1;
    check("t1_async_valid", 64'(vld0), 64'd0);
    check("t1_async_ready", 64'(rdy0), 64'd0);
    check("t1_async_random", 64'(rnd0), 64'd0);
    #1 rst_n = 1'b1;
    #1;
    check("t1_ready_before_edge", 64'(rdy0), 64'd0);
    @(negedge clk);
    check("t1_ready_after_edge", 64'(rdy0), 64'd1);

    // Zero seed forces 64'h1: 29 zero outputs then 2'b01.
    send0(32'h0);
    send0(32'h0);
    @(negedge clk);
    sv0 = 1'b0;
    check("t3_valid", 64'(vld0), 64'd1);
    check("t3_random_before_enable", 64'(rnd0), 64'd0);
    m0 = 64'h1;
    for (int i = 1; i <= 30; i++) begin
      m0 = model_adv(m0, 2);
      en_push0((i == 30) ? 8'h01 : 8'h00);
    end

    // Gaps in enable: output holds, sequence resumes without skipping.
    m0 = model_adv(m0, 2);
    en_push0(8'(m0[1:0]));
    idle0();
    for (int i = 0; i < 10; i++) begin
      idle0();
      check("t4_hold", 64'(rnd0), 64'(m0[1:0]));
    end
    for (int i = 0; i < 6; i++) begin
      m0 = model_adv(m0, 2);
      en_push0(8'(m0[1:0]));
    end
    idle0();

    // Reseed beats a same-cycle enable and seed handshake.
    @(negedge clk);
    rs0 = 1'b1; en0 = 1'b1; sv0 = 1'b1; seed0 = 32'hffff_ffff;
    @(negedge clk);
    check("t5_reseed_valid", 64'(vld0), 64'd0);
    check("t5_reseed_random", 64'(rnd0), 64'd0);
    check("t5_reseed_ready", 64'(rdy0), 64'd1);
    en0 = 1'b0; // rs0 and sv0 still high: word must not be taken
    @(negedge clk);
    rs0 = 1'b0; sv0 = 1'b0;
    seed_stream0(32'h1234_5678, 32'h9abc_def0, 8);
    @(negedge clk);
    rs0 = 1'b1;
    @(negedge clk);
    rs0 = 1'b0;
    check("t5_second_reseed_valid", 64'(vld0), 64'd0);
    seed_stream0(32'h1234_5678, 32'h9abc_def0, 8);

    // Instance 1: warm-up of 16 advances of 8 bits.
    send1(32'hdead_beef);
    send1(32'h0bad_f00d);
    @(negedge clk);
    sv1 = 1'b0;
    check("t6_warm_valid_1", 64'(vld1), 64'd0);
    for (int i = 2; i <= 17; i++) begin
      @(negedge clk);
      check("t6_warm_valid", 64'(vld1), (i == 17) ? 64'd1 : 64'd0);
    end
    m1 = model_adv({32'h0bad_f00d, 32'hdead_beef}, 128);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en1 = 1'b1;
      m1  = model_adv(m1, 8);
      q1.push_back(m1[7:0]);
    end
    @(negedge clk);
    en1 = 1'b0;

    repeat (3) @(negedge clk);
    check("drain_q0", 64'(q0.size()), 64'd0);
    check("drain_q1", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
